uart_tx_fifo: RTL and testbench

- Bus-slave front end for the UART transmit path, on the shared CPU memory bus at the UART window (base 0xffff0040).
- Accepts byte writes from the CPU or a test master, buffers them in a FIFO, and presents them on a valid/ready byte stream to the serializer.
- Decouples bursty software writes from the slow bit rate.
- Exposes a status register for software polling.

---
 rtl/uart_pkg.sv | 46 ++++
 rtl/uart_tx_fifo_sync_fifo.sv | 74 +++++++
 rtl/uart_tx_fifo.sv | 149 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared constants for the UART transmit front end: bus window base,
//   register offsets, STATUS bit positions, bus handshake state encoding,
//   and a helper that assembles the STATUS word.
//   Ports: none (package).
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam logic [31:0] UART_BASE  = 32'hffff_0040;
    localparam logic [31:0] DATA_OFF   = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFF = 32'h0000_0004;

    // Only this address bit distinguishes DATA from STATUS.
    localparam int unsigned REG_SEL_BIT = 2;

    localparam int unsigned EMPTY_BIT = 0;
    localparam int unsigned FULL_BIT  = 1;
    localparam int unsigned OVF_BIT   = 2;
    localparam int unsigned COUNT_LSB = 8;

    localparam int unsigned TX_W = 8;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_STALL,
        BUS_WR_ACK,
        BUS_RD_ACK
    } bus_state_t;

    function automatic logic [31:0] pack_status(
        input logic       empty,
        input logic       full,
        input logic       ovf,
        input logic [7:0] count
    );
        logic [31:0] s;
        s                   = '0;
        s[EMPTY_BIT]        = empty;
        s[FULL_BIT]         = full;
        s[OVF_BIT]          = ovf;
        s[COUNT_LSB +: 8]   = count;
        return s;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with a registered head output. Pointers wrap modulo
//   DEPTH (power of two); count spans 0..DEPTH.
//   Ports:
//     clk, reset  - clock, synchronous active-high reset
//     push, din   - write request and data (ignored when full)
//     pop         - advance head (ignored when empty)
//     dout        - registered head entry
//     empty, full - occupancy flags
//     count       - number of stored entries
// ---------------------------------------------------------------------------
module sync_fifo
    import uart_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned WIDTH = TX_W,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rd_next = rd_ptr + PTR_W'(pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            storage[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_next;
            count  <= count + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
            // The head register only changes when the head entry changes.
            // A push landing exactly on the next head slot (empty FIFO, or
            // one entry being popped) is forwarded from din because the
            // storage write has not happened yet.
            if (push_ok && (wr_ptr == rd_next)) begin
                dout <= din;
            end else if (pop_ok) begin
                dout <= storage[rd_next];
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Bus-slave front end for the UART transmit path. CPU byte writes to DATA
//   are queued in a FIFO and streamed to the serializer over valid/ready.
//   STATUS reports empty/full/overflow and the fill level.
//   Optional feature macro: UART_TX_FIFO_DROP_EN
//     defined   - DATA write while full is acknowledged and dropped, setting
//                 a sticky overflow flag cleared by a STATUS read acknowledge
//     undefined - DATA write while full stalls until space frees up
//   Ports:
//     clk, reset            - clock, synchronous active-high reset
//     enable                - chip select from the address decoder
//     mem_valid, mem_instr  - bus request, fetch flag (fetch flag unused)
//     mem_addr, mem_wstrb   - address (bit 2 decoded), strobes (0 = read)
//     mem_wdata             - write data, low byte used
//     mem_ready, mem_rdata  - one-cycle acknowledge, read data (0 otherwise)
//     tx_data, tx_valid     - head byte and FIFO-not-empty
//     tx_ready              - serializer consumes head byte this cycle
// ---------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        mem_valid,
    input  logic        mem_instr,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    bus_state_t     state;
    logic           fifo_empty;
    logic           fifo_full;
    logic [PTR_W:0] fifo_count;
    logic [7:0]     count_byte;
    logic [31:0]    status;
    logic           ovf;
    logic           accept;
    logic           is_read;
    logic           sel_status;
    logic           data_wr;
    logic           push;
    logic           stall_full;
    logic           unused_bus_bits;

    assign unused_bus_bits = ^{mem_instr, mem_addr[31:3], mem_addr[1:0], mem_wdata[31:8]};

    // mem_ready is high only in the acknowledge cycle, so gating on it stops
    // a still-asserted request from being taken twice.
    assign accept     = enable & mem_valid & ~mem_ready;
    assign is_read    = (mem_wstrb == '0);
    assign sel_status = (mem_addr[REG_SEL_BIT] == STATUS_OFF[REG_SEL_BIT]);
    assign data_wr    = ~is_read & ~sel_status & mem_wstrb[0];
    assign push       = accept & data_wr & ~fifo_full;

    // Count is shown in an 8-bit field; a DEPTH of 256 reads back as 0 when
    // completely full (the full bit still distinguishes it).
    assign count_byte = 8'(fifo_count);
    assign status     = pack_status(fifo_empty, fifo_full, ovf, count_byte);

    assign tx_valid   = ~fifo_empty;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TX_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (tx_ready),
        .din   (mem_wdata[7:0]),
        .dout  (tx_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

`ifdef UART_TX_FIFO_DROP_EN
    logic overflow_set;

    assign stall_full   = 1'b0;
    assign overflow_set = accept & data_wr & fifo_full;

    // Sticky until a read is acknowledged; a new overflow in that same
    // cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (overflow_set) begin
            ovf <= 1'b1;
        end else if (state == BUS_RD_ACK) begin
            ovf <= 1'b0;
        end
    end
`else
    assign stall_full = accept & data_wr & fifo_full;
    assign ovf        = 1'b0;
`endif

    // Bus handshake. A stalled write is simply re-evaluated every cycle it
    // stays requested; dropping the request returns to idle with no push.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= BUS_IDLE;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else begin
            case (state)
                BUS_IDLE, BUS_STALL: begin
                    if (accept) begin
                        if (is_read) begin
                            state     <= BUS_RD_ACK;
                            mem_ready <= 1'b1;
                            mem_rdata <= status;
                        end else if (stall_full) begin
                            state     <= BUS_STALL;
                            mem_ready <= 1'b0;
                            mem_rdata <= '0;
                        end else begin
                            state     <= BUS_WR_ACK;
                            mem_ready <= 1'b1;
                            mem_rdata <= '0;
                        end
                    end else begin
                        state     <= BUS_IDLE;
                        mem_ready <= 1'b0;
                        mem_rdata <= '0;
                    end
                end
                default: begin
                    state     <= BUS_IDLE;
                    mem_ready <= 1'b0;
                    mem_rdata <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Directed and randomized checks of uart_tx_fifo against a queue-based
//   model of the transmit FIFO and the STATUS register.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] A_DATA = 32'hffff_0040;
    localparam logic [31:0] A_STAT = 32'hffff_0044;
`ifdef UART_TX_FIFO_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  model_q [$];
    logic [7:0]  sent [$];
    bit          ovf_m;
    int          max_q;
    bit          mon_en;
    logic [7:0]  hello [5] = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f};

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        int n;
        n = model_q.size();
        s = 32'(n) << 8;
        if (ovf_m)           s = s | 32'h4;
        if (n == int'(DEPTH)) s = s | 32'h2;
        if (n == 0)          s = s | 32'h1;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serializer side: a byte leaves whenever the model holds one and
    // tx_ready is high at the sampling point before the edge.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            chk("tx_valid", 32'(tx_valid), 32'(model_q.size() != 0));
            if (model_q.size() != 0) begin
                chk("tx_data", 32'(tx_data), 32'(model_q[0]));
                if (model_q.size() > max_q) max_q = model_q.size();
                if (tx_ready) sent.push_back(model_q.pop_front());
            end
        end
    end

    task automatic bus_write(input logic [31:0] addr, input logic [3:0] strb,
                             input logic [31:0] data, input int budget,
                             output int lat, output bit acked);
        bit full_at_accept;
        full_at_accept = (model_q.size() == int'(DEPTH));
        enable    = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wstrb = strb;
        mem_wdata = data;
        lat   = 0;
        acked = 1'b0;
        while (!acked && lat < budget) begin
            tick();
            lat++;
            if (mem_ready) acked = 1'b1;
        end
        mem_valid = 1'b0;
        enable    = 1'b0;
        if (acked) begin
            chk("wr_rdata_zero", mem_rdata, 32'h0);
            if (!addr[2] && strb[0]) begin
                if (DROP && full_at_accept) ovf_m = 1'b1;
                else                        model_q.push_back(data[7:0]);
            end
        end
        tick();
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] rd);
        logic [31:0] exp;
        int lat;
        exp       = model_status();
        enable    = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wstrb = 4'h0;
        mem_wdata = 32'h0;
        lat       = 0;
        rd        = 32'hdead_beef;
        while (lat < 4) begin
            tick();
            lat++;
            if (mem_ready) break;
        end
        chk("rd_latency", 32'(lat), 32'd1);
        rd = mem_rdata;
        chk("rd_status", rd, exp);
        if (mem_ready) ovf_m = 1'b0;
        mem_valid = 1'b0;
        enable    = 1'b0;
        tick();
        chk("rd_ready_drop", 32'(mem_ready), 32'd0);
        chk("rd_rdata_idle", mem_rdata, 32'h0);
    endtask

    initial begin
        int          lat;
        bit          ack;
        logic [31:0] rd;
        int          op;
        logic [3:0]  strb;
        bit          stall;

        reset     = 1'b1;
        enable    = 1'b0;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = '0;
        mem_wstrb = '0;
        mem_wdata = '0;
        tx_ready  = 1'b0;
        ovf_m     = 1'b0;
        max_q     = 0;
        mon_en    = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_ready", 32'(mem_ready), 32'd0);
        chk("rst_rdata", mem_rdata, 32'h0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        tick();

        bus_read(A_STAT, rd);
        chk("status_after_reset", rd, 32'h0000_0001);

        // Single byte, serializer not ready
        bus_write(A_DATA, 4'h1, 32'h0000_0048, 4, lat, ack);
        chk("w48_latency", 32'(lat), 32'd1);
        chk("w48_tx_valid", 32'(tx_valid), 32'd1);
        chk("w48_tx_data", 32'(tx_data), 32'h48);
        bus_read(A_STAT, rd);
        chk("w48_status", rd, 32'h0000_0100);
        tx_ready = 1'b1;
        repeat (3) tick();
        tx_ready = 1'b0;
        chk("w48_drained", 32'(tx_valid), 32'd0);

        // Fill to full
        sent.delete();
        for (int i = 0; i < 16; i++) begin
            bus_write(A_DATA, 4'h1, 32'(i), 4, lat, ack);
            chk("fill_latency", 32'(lat), 32'd1);
        end
        bus_read(A_DATA, rd);
        chk("full_status", rd, 32'h0000_1002);

`ifdef UART_TX_FIFO_DROP_EN
        bus_write(A_DATA, 4'h1, 32'h0000_00aa, 4, lat, ack);
        chk("drop_latency", 32'(lat), 32'd1);
        bus_read(A_STAT, rd);
        chk("ovf_status", rd, 32'h0000_1006);
        bus_read(A_STAT, rd);
        chk("ovf_cleared", rd, 32'h0000_1002);
        tx_ready = 1'b1;
        repeat (DEPTH + 3) tick();
        tx_ready = 1'b0;
        chk("drop_sent_count", 32'(sent.size()), 32'd16);
        for (int i = 0; i < 16; i++)
            if (i < sent.size()) chk("drop_order", 32'(sent[i]), 32'(i));

        // Reset mid-operation clears FIFO and the sticky flag
        for (int i = 0; i < 16; i++) bus_write(A_DATA, 4'h1, 32'(8'h30 + i), 4, lat, ack);
        bus_write(A_DATA, 4'h1, 32'h0000_00bb, 4, lat, ack);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_q.delete();
        ovf_m = 1'b0;
        chk("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_mid_tx_data", 32'(tx_data), 32'd0);
        bus_read(A_STAT, rd);
        chk("rst_mid_status", rd, 32'h0000_0001);
`else
        // 17th write stalls; one pop frees space and the write completes
        fork
            bus_write(A_DATA, 4'h1, 32'h0000_00aa, 10, lat, ack);
            begin
                repeat (3) tick();
                tx_ready = 1'b1;
                tick();
                tx_ready = 1'b0;
            end
        join
        chk("stall_acked", 32'(ack), 32'd1);
        chk("stall_latency", 32'(lat), 32'd5);
        tx_ready = 1'b1;
        repeat (DEPTH + 3) tick();
        tx_ready = 1'b0;
        chk("stall_sent_count", 32'(sent.size()), 32'd17);
        for (int i = 0; i < 16; i++)
            if (i < sent.size()) chk("stall_order", 32'(sent[i]), 32'(i));
        if (sent.size() > 16) chk("stall_last", 32'(sent[16]), 32'haa);

        // Abandoned stalled write leaves no trace
        sent.delete();
        for (int i = 0; i < 16; i++) bus_write(A_DATA, 4'h1, 32'(8'h30 + i), 4, lat, ack);
        bus_write(A_DATA, 4'h1, 32'h0000_00bb, 3, lat, ack);
        chk("abandon_no_ack", 32'(ack), 32'd0);
        bus_read(A_STAT, rd);
        chk("abandon_status", rd, 32'h0000_1002);

        // Reset while a write is stalled on a full FIFO
        enable    = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = A_DATA;
        mem_wstrb = 4'h1;
        mem_wdata = 32'h0000_00cc;
        tick();
        chk("rst_stall_ready_a", 32'(mem_ready), 32'd0);
        reset = 1'b1;
        tick();
        chk("rst_stall_ready_b", 32'(mem_ready), 32'd0);
        reset     = 1'b0;
        mem_valid = 1'b0;
        enable    = 1'b0;
        model_q.delete();
        chk("rst_stall_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_stall_tx_data", 32'(tx_data), 32'd0);
        tick();
        chk("rst_stall_ready_c", 32'(mem_ready), 32'd0);
        bus_read(A_STAT, rd);
        chk("rst_stall_status", rd, 32'h0000_0001);
`endif

        // Streaming with the serializer always ready
        sent.delete();
        max_q    = 0;
        tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus_write(A_DATA, 4'h1, 32'(hello[i]), 4, lat, ack);
            chk("hello_latency", 32'(lat), 32'd1);
        end
        repeat (3) tick();
        chk("hello_count", 32'(sent.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < sent.size()) chk("hello_byte", 32'(sent[i]), 32'(hello[i]));
        chk("hello_max_level", 32'(max_q <= 1), 32'd1);
        tx_ready = 1'b0;

        // Randomized mix of data writes, status writes and reads
        for (int k = 0; k < 150; k++) begin
            op       = $urandom_range(0, 9);
            tx_ready = ($urandom_range(0, 2) == 0);
            if (op <= 5) begin
                strb  = 4'($urandom_range(1, 15));
                stall = !DROP && strb[0] && (model_q.size() == int'(DEPTH));
                if (stall) tx_ready = 1'b1;
                bus_write(A_DATA, strb, $urandom, 8, lat, ack);
                chk("rnd_wr_latency", 32'(lat), stall ? 32'd2 : 32'd1);
            end else if (op == 6) begin
                bus_write(A_STAT, 4'($urandom_range(1, 15)), $urandom, 8, lat, ack);
                chk("rnd_stat_wr_latency", 32'(lat), 32'd1);
            end else begin
                bus_read(($urandom_range(0, 1) != 0) ? A_STAT : A_DATA, rd);
            end
            repeat ($urandom_range(0, 1)) tick();
        end

        tx_ready = 1'b1;
        repeat (DEPTH + 4) tick();
        tx_ready = 1'b0;
        chk("final_tx_valid", 32'(tx_valid), 32'd0);
        bus_read(A_STAT, rd);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
